vga_timing_checker: RTL
=======================

// Module: vga_timing_checker
// PURPOSE
// - Sink-side monitor on the VGA bus: consumes a vga_if.in modport, checks hcount/vcount sequencing,
//   blank/sync windows and black-during-blank rgb against 800x600@60 timing, reports lock and errors.
// - Sits on any stage boundary of the draw pipeline (timing gen -> bg -> sprites -> out), sim and FPGA.
// PARAMETERS
// - H_ACTIVE 800 visible pixels/line; H_TOTAL 1056 pixels/line; H_SYNC_S 840, H_SYNC_E 968 (hsync=[S,E))
// - V_ACTIVE 600 visible lines; V_TOTAL 628 lines/frame; V_SYNC_S 601, V_SYNC_E 605 (vsync=[S,E))
// - CNT_W 16 width of err_cnt / frame_cnt
// PORTS
// - clk         in   1      pixel clock (40 MHz)
// - rst_n       in   1      async reset, active-low
// - vga_in      in   vga_if.in  monitored bus: hcount,vcount[10:0], hsync,vsync,hblnk,vblnk, rgb[11:0]
// - clr_err     in   1      sync clear of err_flags and err_cnt
// - locked      out  1      checker aligned to bus
// - frame_start out  1      1-cycle pulse, registered, when (0,0) sampled while locked
// - err_pulse   out  1      1-cycle pulse per cycle with >=1 failed check
// - err_flags   out  5      sticky: [0]H_SEQ [1]V_SEQ [2]BLNK [3]SYNC [4]RGB_IN_BLANK
// - err_cnt     out  CNT_W  saturating count of err_pulse cycles
// - frame_cnt   out  CNT_W  wrapping count of frame_start pulses
// BEHAVIOUR
// - Reset: all outputs 0, FSM=UNLOCKED, input stage regs 0.
// - Stage 1 registers every vga_in field; all checks use stage-1 values vs stage-1 previous values.
// - Latency: bus sample -> check result registered on outputs = 2 clk.
// - FSM UNLOCKED: no checks, no counting; on sampled hcount==0 && vcount==0 -> LOCKED (frame_start fires).
// - FSM LOCKED: each cycle evaluate:
//   H_SEQ: hcount != (prev_h==H_TOTAL-1 ? 0 : prev_h+1)
//   V_SEQ: on h wrap vcount != (prev_v==V_TOTAL-1 ? 0 : prev_v+1); else vcount != prev_v
//   BLNK: hblnk != (hcount>=H_ACTIVE) or vblnk != (vcount>=V_ACTIVE)
//   SYNC: hsync != (H_SYNC_S<=hcount<H_SYNC_E) or vsync != (V_SYNC_S<=vcount<V_SYNC_E)
//   RGB_IN_BLANK: (hblnk|vblnk) && rgb!=12'h000
// - Any H_SEQ or V_SEQ failure -> LOCKED->UNLOCKED next cycle (relock at next (0,0)); BLNK/SYNC/RGB
//   failures flag only, lock kept.
// - Failing cycle: err_pulse=1, matching err_flags bits set (OR, sticky), err_cnt+1, saturates at all-ones.
// - clr_err: err_flags<=0, err_cnt<=0; same-cycle new error wins (flags=new bits, err_cnt=1).
// - frame_cnt wraps all-ones->0; not cleared by clr_err, only by reset.
// - Compares use 11-bit unsigned; out-of-range counts (>=TOTAL) fail H_SEQ/V_SEQ, never index anything.
// - Reset mid-frame: outputs 0 asynchronously; after release stays UNLOCKED until next (0,0).
// STRUCTURE
// - vga_pkg: 800x600 timing localparams (H_*/V_*), err bit index enum err_bit_e, checker state enum.
// - One sub-module: vga_timing_ref (combinational expected hblnk/vblnk/hsync/vsync from counts);
//   top holds input stage, FSM, sticky/counter regs.
// TESTING
// - Clean bus from vga_timing gen, 3 frames -> locked=1 after first (0,0), frame_cnt=3, err_cnt=0, flags=0.
// - Skip hcount 500->502 while locked -> err_pulse 1 cycle, flags=5'b00001, locked=0, relock next frame.
// - Force hsync=1 at hcount=100 -> flags=5'b01000, err_cnt=1, locked stays 1.
// - rgb=12'hF00 at hcount=900 -> flags=5'b10000; then clr_err -> flags=0, err_cnt=0, frame_cnt kept.
// - Inject 70000 error cycles with CNT_W=16 -> err_cnt=16'hFFFF, no wrap.
// - Assert rst_n low at vcount=300 -> all outputs 0 same edge; release -> locked=0 until (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 800x600@60 timing constants and types for the VGA bus timing checker.
package vga_pkg;
   localparam int H_ACTIVE = 800;
   localparam int H_TOTAL  = 1056;
   localparam int H_SYNC_S = 840;
   localparam int H_SYNC_E = 968;
   localparam int V_ACTIVE = 600;
   localparam int V_TOTAL  = 628;
   localparam int V_SYNC_S = 601;
   localparam int V_SYNC_E = 605;
   localparam int ERR_W    = 5;

   typedef enum logic [2:0] {
      ERR_H_SEQ        = 3'd0,
      ERR_V_SEQ        = 3'd1,
      ERR_BLNK         = 3'd2,
      ERR_SYNC         = 3'd3,
      ERR_RGB_IN_BLANK = 3'd4
   } err_bit_e;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } chk_state_e;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_sample_t;
endpackage

// File: rtl/vga_if.sv
// VGA draw-pipeline bus: pixel/line counters, sync and blank strobes, 12-bit colour.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in (input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_ref.sv
// Combinational reference: the blank and sync levels a correct bus shows at a given count.
module vga_timing_ref #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_SYNC_S = vga_pkg::H_SYNC_S,
   parameter int H_SYNC_E = vga_pkg::H_SYNC_E,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_SYNC_S = vga_pkg::V_SYNC_S,
   parameter int V_SYNC_E = vga_pkg::V_SYNC_E
) (
   input  logic [10:0] hcount,
   input  logic [10:0] vcount,
   output logic        hblnk,
   output logic        vblnk,
   output logic        hsync,
   output logic        vsync
);
   localparam logic [10:0] HA  = 11'(H_ACTIVE);
   localparam logic [10:0] HSS = 11'(H_SYNC_S);
   localparam logic [10:0] HSE = 11'(H_SYNC_E);
   localparam logic [10:0] VA  = 11'(V_ACTIVE);
   localparam logic [10:0] VSS = 11'(V_SYNC_S);
   localparam logic [10:0] VSE = 11'(V_SYNC_E);

   always_comb begin
      hblnk = (hcount >= HA);
      vblnk = (vcount >= VA);
      hsync = (hcount >= HSS) && (hcount < HSE);
      vsync = (vcount >= VSS) && (vcount < VSE);
   end
endmodule

// File: rtl/vga_timing_checker.sv
// Sink-side VGA bus monitor: locks onto (0,0), checks count sequencing, blank/sync windows
// and black-during-blank colour, and reports lock, frame starts and sticky/counted errors.
module vga_timing_checker #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_TOTAL  = vga_pkg::H_TOTAL,
   parameter int H_SYNC_S = vga_pkg::H_SYNC_S,
   parameter int H_SYNC_E = vga_pkg::H_SYNC_E,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_TOTAL  = vga_pkg::V_TOTAL,
   parameter int V_SYNC_S = vga_pkg::V_SYNC_S,
   parameter int V_SYNC_E = vga_pkg::V_SYNC_E,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   vga_if.in                vga_in,
   input  logic             clr_err,
   output logic             locked,
   output logic             frame_start,
   output logic             err_pulse,
   output logic [4:0]       err_flags,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] frame_cnt
);
   import vga_pkg::*;

   localparam logic [10:0]      H_LAST  = 11'(H_TOTAL - 1);
   localparam logic [10:0]      V_LAST  = 11'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   chk_state_e       state_q, state_d;
   vga_sample_t      smp_q, smp_d;
   logic             vld_q, vld_d;
   logic [10:0]      h_prev_q, h_prev_d, v_prev_q, v_prev_d;
   logic             exp_hblnk, exp_vblnk, exp_hsync, exp_vsync;
   logic [10:0]      h_exp, v_exp;
   logic             at_origin, seq_err;
   logic [ERR_W-1:0] err_new;
   logic             frame_start_q, frame_start_d, err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0] err_flags_q, err_flags_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d, frame_cnt_q, frame_cnt_d;

   // vld keeps the all-zero reset contents of the stage from looking like a sampled (0,0).
   always_comb begin
      smp_d    = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                   hsync: vga_in.hsync, vsync: vga_in.vsync,
                   hblnk: vga_in.hblnk, vblnk: vga_in.vblnk, rgb: vga_in.rgb};
      vld_d    = 1'b1;
      h_prev_d = smp_q.hcount;
      v_prev_d = smp_q.vcount;
   end

   vga_timing_ref #(
      .H_ACTIVE(H_ACTIVE), .H_SYNC_S(H_SYNC_S), .H_SYNC_E(H_SYNC_E),
      .V_ACTIVE(V_ACTIVE), .V_SYNC_S(V_SYNC_S), .V_SYNC_E(V_SYNC_E)
   ) u_ref (
      .hcount(smp_q.hcount), .vcount(smp_q.vcount),
      .hblnk(exp_hblnk), .vblnk(exp_vblnk), .hsync(exp_hsync), .vsync(exp_vsync)
   );

   always_comb begin
      h_exp = (h_prev_q == H_LAST) ? 11'd0 : h_prev_q + 11'd1;
      if (h_prev_q == H_LAST) begin
         v_exp = (v_prev_q == V_LAST) ? 11'd0 : v_prev_q + 11'd1;
      end else begin
         v_exp = v_prev_q;
      end
      err_new = '0;
      if (state_q == ST_LOCKED) begin
         err_new[ERR_H_SEQ]        = (smp_q.hcount != h_exp);
         err_new[ERR_V_SEQ]        = (smp_q.vcount != v_exp);
         err_new[ERR_BLNK]         = (smp_q.hblnk != exp_hblnk) || (smp_q.vblnk != exp_vblnk);
         err_new[ERR_SYNC]         = (smp_q.hsync != exp_hsync) || (smp_q.vsync != exp_vsync);
         err_new[ERR_RGB_IN_BLANK] = (smp_q.hblnk || smp_q.vblnk) && (smp_q.rgb != 12'h000);
      end
      seq_err   = err_new[ERR_H_SEQ] || err_new[ERR_V_SEQ];
      at_origin = vld_q && (smp_q.hcount == 11'd0) && (smp_q.vcount == 11'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_UNLOCKED;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_UNLOCKED: if (at_origin) state_d = ST_LOCKED;
         ST_LOCKED:   if (seq_err)   state_d = ST_UNLOCKED;
         default:     state_d = ST_UNLOCKED;
      endcase
   end

   // A clear coinciding with a new failure keeps only that failure.
   always_comb begin
      frame_start_d = at_origin && ((state_q == ST_UNLOCKED) || !seq_err);
      err_pulse_d   = |err_new;
      err_flags_d   = clr_err ? err_new : (err_flags_q | err_new);
      if (clr_err) begin
         err_cnt_d = err_pulse_d ? CNT_W'(1) : '0;
      end else if (err_pulse_d && (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end else begin
         err_cnt_d = err_cnt_q;
      end
      frame_cnt_d = frame_start_d ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp_q         <= '0;
         vld_q         <= 1'b0;
         h_prev_q      <= '0;
         v_prev_q      <= '0;
         frame_start_q <= 1'b0;
         err_pulse_q   <= 1'b0;
         err_flags_q   <= '0;
         err_cnt_q     <= '0;
         frame_cnt_q   <= '0;
      end else begin
         smp_q         <= smp_d;
         vld_q         <= vld_d;
         h_prev_q      <= h_prev_d;
         v_prev_q      <= v_prev_d;
         frame_start_q <= frame_start_d;
         err_pulse_q   <= err_pulse_d;
         err_flags_q   <= err_flags_d;
         err_cnt_q     <= err_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign locked      = (state_q == ST_LOCKED);
   assign frame_start = frame_start_q;
   assign err_pulse   = err_pulse_q;
   assign err_flags   = err_flags_q;
   assign err_cnt     = err_cnt_q;
   assign frame_cnt   = frame_cnt_q;
endmodule
